mux8_scan_seq: RTL and testbench
================================

MUX8_SCAN_SEQ -- requirements
Module: mux8_scan_seq

Interface
REQ-001 SHALL have parameter DWELL, default 1, number of clk cycles each select value is held (legal 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream word available.
REQ-005 SHALL have port in_ready  output  1  block can accept a word.
REQ-006 SHALL have port in_data  input  8  word to present to the 8:1 mux.
REQ-007 SHALL have ports i0..i7  output  1 each  mux data inputs; i0=in_data[0] .. i7=in_data[7].
REQ-008 SHALL have ports s0, s1, s2  output  1 each  mux select; s0 is the LSB of the select count.
REQ-009 SHALL have port y  input  1  combinational output returned by the downstream mux8x1.
REQ-010 SHALL have port out_valid  output  1  captured word available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts captured word.
REQ-012 SHALL have port out_data  output  8  captured word; bit k = y sampled while select = k.
REQ-013 SHALL have port err  output  1  loopback mismatch flag, qualified by out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid&&in_ready SHALL latch in_data onto i0..i7, clear select and dwell counters, clear err, enter SCAN; otherwise remain in IDLE.
REQ-016 i0..i7 SHALL hold the latched word unchanged from acceptance until the next acceptance.
REQ-017 SCAN: select {s2,s1,s0} SHALL hold each value 0..7 for exactly DWELL cycles, ascending, no gaps.
REQ-018 On the last dwell cycle of select k SHALL sample y into out_data[k] at that rising edge.
REQ-019 After sampling at select 7 SHALL enter DONE; select SHALL wrap to 0.
REQ-020 Latency with DWELL=1: accept at edge 0, SCAN during cycles 1..8, out_valid high from cycle 9; general: 8*DWELL+1 cycles accept-to-out_valid.
REQ-021 DONE: out_data and err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 DONE: on out_ready=1 SHALL return to IDLE next edge; in_valid is not accepted in that same cycle.
REQ-023 in_valid during SCAN or DONE SHALL be ignored (no overwrite of latched word).
REQ-024 out_ready outside DONE SHALL have no effect.
REQ-025 Select outputs in IDLE and DONE SHALL be 0.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, i0..i7=0, s0..s2=0, out_data=0, out_valid=0, err=0, counters=0; in_ready=1 once state is IDLE.
REQ-027 Reset asserted mid-SCAN SHALL abort the frame; no partial out_valid afterwards.
REQ-028 First acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro MUX8_SCAN_CHECK_EN defined: at each sample of select k SHALL compare y with latched bit k; any mismatch sets err, sticky until next acceptance.
REQ-030 Macro MUX8_SCAN_CHECK_EN undefined: err SHALL be tied 0, no comparison logic; port list unchanged.

Verification
REQ-031 DWELL=1, in_data=8'hA5 with correct mux8x1 -> select 0..7 over cycles 1..8, out_valid at cycle 9, out_data=8'hA5, err=0.
REQ-032 DWELL=3, in_data=8'h3C -> each select held 3 cycles, out_valid at cycle 25, out_data=8'h3C.
REQ-033 CHECK_EN, y forced 0, in_data=8'h01 -> out_data=8'h00, err=1; next frame 8'h00 with real mux -> err=0.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid, out_data stable, in_ready=0, in_valid word 8'hFF ignored; out_ready=1 -> IDLE next cycle.
REQ-035 rst_n pulsed low at select 4 -> all outputs 0 asynchronously, no out_valid, next word 8'h5A completes normally.
REQ-036 Back-to-back in_valid=1, out_ready=1 constant, words 8'h12, 8'h34 -> two frames 10 cycles apart (DWELL=1), out_data 8'h12 then 8'h34.

Source files
------------

// File: rtl/mux8_scan_seq.sv
// Loopback scanner: drives a latched byte onto an external 8:1 mux and walks its select, rebuilding the byte from y.
// Latency 8*DWELL+1 cycles from acceptance to out_valid; in_ready only in IDLE, result held in DONE until out_ready.
// Optional loopback compare under MUX8_SCAN_CHECK_EN (err sticky per frame); without it err is tied low.
module mux8_scan_seq #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       i0,
    output logic       i1,
    output logic       i2,
    output logic       i3,
    output logic       i4,
    output logic       i5,
    output logic       i6,
    output logic       i7,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    input  logic       y,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

    state_t     state_q, state_d;
    logic [7:0] word_q, word_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] dwell_q, dwell_d;
    logic [7:0] out_data_q, out_data_d;
    logic       err_q, err_d;

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        sel_d      = sel_q;
        dwell_d    = dwell_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    sel_d   = 3'd0;
                    dwell_d = 4'd0;
                    err_d   = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    // y has settled for the whole dwell window; capture on its final edge
                    out_data_d[sel_q] = y;
`ifdef MUX8_SCAN_CHECK_EN
                    if (y != word_q[sel_q]) begin
                        err_d = 1'b1;
                    end
`endif
                    dwell_d = 4'd0;
                    if (sel_q == 3'd7) begin
                        sel_d   = 3'd0;
                        state_d = DONE;
                    end else begin
                        sel_d = sel_q + 3'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                dwell_d = 4'd0;
            end
        endcase
`ifndef MUX8_SCAN_CHECK_EN
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            word_q     <= 8'h00;
            sel_q      <= 3'd0;
            dwell_q    <= 4'd0;
            out_data_q <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            sel_q      <= sel_d;
            dwell_q    <= dwell_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign {i7, i6, i5, i4, i3, i2, i1, i0} = word_q;
    assign {s2, s1, s0}                     = sel_q;
    assign in_ready                         = (state_q == IDLE);
    assign out_valid                        = (state_q == DONE);
    assign out_data                         = out_data_q;
    assign err                              = err_q;

endmodule

// File: tb/tb_mux8_scan_seq.sv
// Bench for mux8_scan_seq: two instances (DWELL=1 and DWELL=3) each looped through a behavioural 8:1 mux.
module tb_mux8_scan_seq;

    localparam int DA = 1;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid_a = 1'b0, out_ready_a = 1'b0, force_a = 1'b0;
    logic [7:0] in_data_a = 8'h00;
    logic       in_ready_a, out_valid_a, err_a, y_a;
    logic [7:0] iv_a, out_data_a;
    logic [2:0] sel_a;

    logic       in_valid_b = 1'b0, out_ready_b = 1'b0, force_b = 1'b0;
    logic [7:0] in_data_b = 8'h00;
    logic       in_ready_b, out_valid_b, err_b, y_b;
    logic [7:0] iv_b, out_data_b;
    logic [2:0] sel_b;

    // Downstream mux8x1, optionally stuck at 0
    assign y_a = force_a ? 1'b0 : iv_a[sel_a];
    assign y_b = force_b ? 1'b0 : iv_b[sel_b];

    mux8_scan_seq #(.DWELL(DA)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .i0(iv_a[0]), .i1(iv_a[1]), .i2(iv_a[2]), .i3(iv_a[3]),
        .i4(iv_a[4]), .i5(iv_a[5]), .i6(iv_a[6]), .i7(iv_a[7]),
        .s0(sel_a[0]), .s1(sel_a[1]), .s2(sel_a[2]), .y(y_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a), .err(err_a)
    );

    mux8_scan_seq #(.DWELL(DB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .i0(iv_b[0]), .i1(iv_b[1]), .i2(iv_b[2]), .i3(iv_b[3]),
        .i4(iv_b[4]), .i5(iv_b[5]), .i6(iv_b[6]), .i7(iv_b[7]),
        .s0(sel_b[0]), .s1(sel_b[1]), .s2(sel_b[2]), .y(y_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .err(err_b)
    );

    int checks = 0;
    int failures = 0;
    int which = 0;

    logic [7:0] c_iv, c_od;
    logic [2:0] c_sel;
    logic       c_ir, c_ov, c_err;

    always_comb begin
        if (which == 1) begin
            c_iv = iv_b; c_od = out_data_b; c_sel = sel_b;
            c_ir = in_ready_b; c_ov = out_valid_b; c_err = err_b;
        end else begin
            c_iv = iv_a; c_od = out_data_a; c_sel = sel_a;
            c_ir = in_ready_a; c_ov = out_valid_a; c_err = err_a;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        if (which == 1) begin
            in_valid_b = v; in_data_b = d; out_ready_b = r;
        end else begin
            in_valid_a = v; in_data_a = d; out_ready_a = r;
        end
    endtask

    // One full frame: accept, scan, hold in DONE for 'hold' cycles with a stray word offered, then release.
    task automatic run_frame(input int inst, input logic [7:0] w, input logic f, input int hold);
        int d;
        int n;
        logic [7:0] yv;
        logic exp_err;
        which = inst;
        d = (inst == 1) ? DB : DA;
        if (inst == 1) force_b = f; else force_a = f;
        yv = f ? 8'h00 : w;
`ifdef MUX8_SCAN_CHECK_EN
        exp_err = |(yv ^ w);
`else
        exp_err = 1'b0;
`endif
        n = 0;
        while (!c_ir && n < 50) begin
            step();
            n++;
        end
        chk("in_ready_before_accept", 32'(c_ir), 32'd1);
        drive(1'b1, w, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        chk("latched_word", 32'(c_iv), 32'(w));
        for (int c = 1; c <= 8 * d; c++) begin
            chk("scan_sel", 32'(c_sel), 32'((c - 1) / d));
            chk("scan_no_valid", 32'(c_ov), 32'd0);
            chk("scan_word_held", 32'(c_iv), 32'(w));
            drive(1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
            step();
        end
        chk("out_valid", 32'(c_ov), 32'd1);
        chk("out_data", 32'(c_od), 32'(yv));
        chk("err", 32'(c_err), 32'(exp_err));
        chk("done_sel", 32'(c_sel), 32'd0);
        drive(1'b1, 8'hFF, 1'b0);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(c_ov), 32'd1);
            chk("hold_data", 32'(c_od), 32'(yv));
            chk("hold_err", 32'(c_err), 32'(exp_err));
            chk("hold_in_ready", 32'(c_ir), 32'd0);
            chk("hold_word", 32'(c_iv), 32'(w));
        end
        drive(1'b1, 8'hFF, 1'b1);
        step();
        chk("release_valid", 32'(c_ov), 32'd0);
        chk("release_in_ready", 32'(c_ir), 32'd1);
        chk("release_no_accept", 32'(c_iv), 32'(w));
        drive(1'b0, 8'h00, 1'b0);
        if (inst == 1) force_b = 1'b0; else force_a = 1'b0;
    endtask

    int         nv;
    int         t_v [2];
    logic [7:0] d_v [2];
    bit         seen_acc;
    int         n_wait;

    initial begin
        #1 rst_n = 1'b0;
        #3;
        which = 0;
        chk("rst_in_ready", 32'(c_ir), 32'd1);
        chk("rst_out_valid", 32'(c_ov), 32'd0);
        chk("rst_sel", 32'(c_sel), 32'd0);
        chk("rst_word", 32'(c_iv), 32'd0);
        chk("rst_out_data", 32'(c_od), 32'd0);
        chk("rst_err", 32'(c_err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset accepts; DWELL=1 baseline
        run_frame(0, 8'hA5, 1'b0, 0);
        run_frame(1, 8'h3C, 1'b0, 1);
        run_frame(0, 8'h01, 1'b1, 2);
        run_frame(0, 8'h00, 1'b0, 0);
        run_frame(0, 8'hC3, 1'b0, 10);

        for (int r = 0; r < 6; r++) begin
            run_frame(int'($urandom % 2), 8'($urandom), 1'(($urandom % 4) == 0), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a scan
        which = 0;
        drive(1'b1, 8'h77, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        n_wait = 0;
        while (c_sel != 3'd4 && n_wait < 20) begin
            step();
            n_wait++;
        end
        chk("reached_sel4", 32'(c_sel), 32'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_word", 32'(c_iv), 32'd0);
        chk("midrst_sel", 32'(c_sel), 32'd0);
        chk("midrst_out_data", 32'(c_od), 32'd0);
        chk("midrst_valid", 32'(c_ov), 32'd0);
        chk("midrst_err", 32'(c_err), 32'd0);
        chk("midrst_in_ready", 32'(c_ir), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk("post_rst_no_valid", 32'(c_ov), 32'd0);
        end
        run_frame(0, 8'h5A, 1'b0, 0);

        // Back-to-back frames with constant valid/ready
        which = 0;
        nv = 0;
        seen_acc = 1'b0;
        t_v[0] = 0; t_v[1] = 0; d_v[0] = 8'h00; d_v[1] = 8'h00;
        drive(1'b1, 8'h12, 1'b1);
        for (int t = 1; t <= 25; t++) begin
            step();
            if (!c_ir && !seen_acc) begin
                seen_acc = 1'b1;
                drive(1'b1, 8'h34, 1'b1);
            end
            if (c_ov && nv < 2) begin
                t_v[nv] = t;
                d_v[nv] = c_od;
                nv++;
            end
        end
        chk("b2b_frames", 32'(nv), 32'd2);
        chk("b2b_first_time", 32'(t_v[0]), 32'd9);
        chk("b2b_spacing", 32'(t_v[1] - t_v[0]), 32'd10);
        chk("b2b_data0", 32'(d_v[0]), 32'h12);
        chk("b2b_data1", 32'(d_v[1]), 32'h34);
        drive(1'b0, 8'h00, 1'b1);
        n_wait = 0;
        while (!c_ir && n_wait < 40) begin
            step();
            n_wait++;
        end
        chk("b2b_drain", 32'(c_ir), 32'd1);
        drive(1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
